bus_capture_fifo: RTL and testbench
===================================

BUS_CAPTURE_FIFO -- requirements
Module: bus_capture_fifo

Interface
- Parameters:
REQ-001 DEPTH, 16, number of buffered words; SHALL be a power of two, at least 2.
REQ-002 WIDTH, 16, word width; SHALL match the processor bus width.
- Ports:
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 bus  input  WIDTH  processor bus value to capture.
REQ-006 bus_valid  input  1  capture strobe; bus SHALL be sampled when high.
REQ-007 clear  input  1  synchronous flush request.
REQ-008 out_data  output  WIDTH  oldest buffered word; first-word fall-through.
REQ-009 out_valid  output  1  high when out_data holds a valid word.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 count  output  log2(DEPTH)+1  number of words held, 0..DEPTH.
REQ-012 full  output  1  high when count equals DEPTH.
REQ-013 empty  output  1  high when count equals 0.
REQ-014 overflow  output  1  sticky flag; a capture was dropped.
REQ-015 drop_count  output  8  number of dropped captures, saturating.

Function
REQ-016 Push condition: bus_valid high, clear low, and either full low or a pop occurs in the same cycle.
REQ-017 Pop condition: out_valid high, out_ready high, clear low.
REQ-018 On push, bus SHALL be written at the write pointer; the write pointer SHALL increment modulo DEPTH.
REQ-019 On pop, the read pointer SHALL increment modulo DEPTH.
REQ-020 count SHALL change as follows:
- +1 on push only;
- -1 on pop only;
- unchanged on simultaneous push and pop.
REQ-021 A word pushed at edge N SHALL appear on out_data with out_valid high from edge N onward if the FIFO was empty (one-cycle latency, no extra bubble).
REQ-022 out_valid SHALL equal not empty; out_data SHALL be all zeros while empty.
REQ-023 Words SHALL leave in strict arrival order; none SHALL be duplicated or lost except by a drop (REQ-024).
REQ-024 Drop: bus_valid high while full with no pop in that cycle; the word SHALL be discarded, overflow SHALL set, and drop_count SHALL increment, saturating at 255.
REQ-025 Full with simultaneous pop and bus_valid: this SHALL be a push, not a drop; count SHALL remain DEPTH.
REQ-026 A pop while empty SHALL be impossible (out_valid low); out_ready SHALL be ignored while empty.
REQ-027 clear high SHALL, at the next edge:
- zero both pointers, count, overflow and drop_count;
- ignore bus_valid and out_ready in that cycle.
REQ-028 overflow SHALL stay high until clear or reset, regardless of later pops.
REQ-029 full and empty SHALL be derived from registered count with no combinational path from bus_valid or out_ready.
REQ-030 Pointer wrap from DEPTH-1 to 0 SHALL not disturb ordering or count.

Reset
REQ-031 With resetn low at a rising edge, the block SHALL set:
- both pointers 0, count 0;
- empty 1, full 0, out_valid 0, out_data 0;
- overflow 0, drop_count 0.
REQ-032 Reset SHALL take priority over clear, push and pop; memory contents need not be cleared.
REQ-033 Reset asserted mid-stream SHALL discard all buffered words; the first push after release SHALL appear as the next out_data.

Verification
REQ-034 Push 0x1234 into the empty FIFO with out_ready low -> after the edge: out_valid=1, out_data=0x1234, count=1, empty=0.
REQ-035 Push 16 words 0x0000..0x000F, then a 17th word 0xBEEF, with out_ready low -> full=1, overflow=1, drop_count=1; draining yields 0x0000..0x000F in order, and 0xBEEF is never seen.
REQ-036 Full FIFO with bus_valid=1 (0xAAAA) and out_ready=1 in the same cycle -> count stays 16, overflow stays 0, and 0xAAAA emerges last.
REQ-037 Drive bus_valid continuously for 300 cycles with out_ready low -> drop_count saturates at 255; a following clear -> count=0, overflow=0, drop_count=0, empty=1.
REQ-038 Alternate push/pop for 40 words so the pointers wrap twice -> output sequence equals input sequence and count never exceeds 1.
REQ-039 Assert resetn low for 2 cycles with 5 words buffered -> all outputs at reset values; the next push of 0x00C3 is the next word read out.

Source files
------------

// File: rtl/bus_capture_fifo.sv
// ---------------------------------------------------------------------------
// bus_capture_fifo
//
// Captures processor bus words on a strobe into a first-word fall-through
// FIFO. Captures that arrive while the FIFO is full (and nothing leaves in
// the same cycle) are dropped. A sticky overflow flag and a saturating drop
// counter record them.
//
// Ports
//   clock       in   single clock, all state updates on the rising edge
//   resetn      in   synchronous active-low reset (highest priority)
//   bus         in   WIDTH-bit bus value to capture
//   bus_valid   in   capture strobe
//   clear       in   synchronous flush of pointers, count and drop status
//   out_data    out  oldest buffered word, zero while empty
//   out_valid   out  out_data holds a valid word (not empty)
//   out_ready   in   consumer accepts out_data this cycle
//   count       out  words held, 0..DEPTH
//   full        out  count == DEPTH
//   empty       out  count == 0
//   overflow    out  sticky: at least one capture was dropped
//   drop_count  out  number of dropped captures, saturates at 255
// ---------------------------------------------------------------------------
module bus_capture_fifo #(
    parameter int DEPTH = 16,   // power of two, >= 2
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         bus,
    input  logic                     bus_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic push;
    logic pop;
    logic drop;

    // Status comes only from the registered count, so full/empty/out_valid
    // never depend combinationally on bus_valid or out_ready.
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a capture when the consumer is reading.
    assign pop  = out_valid & out_ready & ~clear;
    assign push = bus_valid & ~clear & (~full | pop);
    assign drop = bus_valid & ~clear & full & ~pop;

    // Fall-through read: the head word is visible as soon as it is stored.
    assign out_data = empty ? '0 : mem_q[rd_ptr_q];

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through this block leaves a variable unassigned (no latches).
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else begin
            // Pointers are AW bits wide and DEPTH is a power of two, so the
            // natural wrap of the adder gives modulo-DEPTH behaviour.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            if (drop) begin
                overflow_d = 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_d = drop_count_q + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample their next value from the same pre-edge snapshot.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable
    // because out_data is masked while empty and pointers restart at zero.
    always_ff @(posedge clock) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q] <= bus;
        end
    end

endmodule

// File: tb/tb_bus_capture_fifo.sv
// ---------------------------------------------------------------------------
// tb_bus_capture_fifo
//
// Directed stimulus against bus_capture_fifo. A queue-based model tracks the
// words that must be held, the sticky overflow flag and the drop count; a
// compare process checks every DUT output against it on each falling edge.
// Literal expectations on top of that pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_bus_capture_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] bus;
    logic             bus_valid;
    logic             clear;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [7:0]       drop_count;

    always #5 clock = ~clock;

    bus_capture_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus),
        .bus_valid  (bus_valid),
        .clear      (clear),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Model state: words held, oldest first.
    logic [WIDTH-1:0] mq [$];
    bit               m_ovf = 1'b0;
    int               m_dc  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the rising edge,
    // then return shortly after the following falling edge.
    task automatic step(input bit bv, input logic [WIDTH-1:0] b,
                        input bit rdy, input bit clr, input bit rstn);
        bit was_full;
        bit m_pop;
        logic [WIDTH-1:0] dummy;
        bus_valid = bv;
        bus       = b;
        out_ready = rdy;
        clear     = clr;
        resetn    = rstn;
        @(posedge clock);
        if (!rstn || clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_dc  = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            m_pop    = (mq.size() > 0) && rdy;
            if (m_pop) dummy = mq.pop_front();
            if (bv) begin
                if (!was_full || m_pop) begin
                    mq.push_back(b);
                end else begin
                    m_ovf = 1'b1;
                    if (m_dc < 255) m_dc++;
                end
            end
        end
        @(negedge clock);
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (check_en) begin
            check("count",      32'(count),      32'(mq.size()));
            check("empty",      32'(empty),      32'(mq.size() == 0));
            check("full",       32'(full),       32'(mq.size() == DEPTH));
            check("out_valid",  32'(out_valid),  32'(mq.size() != 0));
            check("out_data",   32'(out_data),   (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            check("overflow",   32'(overflow),   32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_dc));
        end
    end

    initial begin
        int max_cnt;
        logic [WIDTH-1:0] last_word;

        bus_valid = 1'b0;
        bus       = '0;
        out_ready = 1'b0;
        clear     = 1'b0;
        resetn    = 1'b0;

        // Reset state.
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        check_en = 1'b1;
        check("rst_empty",     32'(empty),      32'd1);
        check("rst_full",      32'(full),       32'd0);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_data",  32'(out_data),   32'h0);
        check("rst_count",     32'(count),      32'd0);

        // out_ready while empty must not pop anything.
        step(0, '0, 1, 0, 1);

        // Single push into the empty FIFO: visible after one edge.
        step(1, 16'h1234, 0, 0, 1);
        check("push1_valid", 32'(out_valid), 32'd1);
        check("push1_data",  32'(out_data),  32'h1234);
        check("push1_count", 32'(count),     32'd1);
        check("push1_empty", 32'(empty),     32'd0);

        // clear with bus_valid and out_ready high: both ignored.
        step(1, 16'h7777, 1, 1, 1);
        check("clr_count", 32'(count), 32'd0);

        // Fill with 0..15, then 0xBEEF is dropped.
        for (int i = 0; i < DEPTH; i++) step(1, 16'(i), 0, 0, 1);
        step(1, 16'hBEEF, 0, 0, 1);
        check("ovf_full",  32'(full),       32'd1);
        check("ovf_flag",  32'(overflow),   32'd1);
        check("ovf_drops", 32'(drop_count), 32'd1);
        check("ovf_count", 32'(count),      32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(out_data), 32'(i));
            step(0, '0, 1, 0, 1);
        end
        check("drain_empty",  32'(empty),     32'd1);
        check("drain_sticky", 32'(overflow),  32'd1);

        // Full with simultaneous capture and pop: a push, not a drop.
        step(0, '0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 16'(16'h0100 + i), 0, 0, 1);
        step(1, 16'hAAAA, 1, 0, 1);
        check("pp_count", 32'(count),    32'd16);
        check("pp_ovf",   32'(overflow), 32'd0);
        check("pp_head",  32'(out_data), 32'h0101);
        last_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last_word = out_data;
            step(0, '0, 1, 0, 1);
        end
        check("pp_last", 32'(last_word), 32'hAAAA);

        // 300 continuous captures with no reader: drop count saturates.
        for (int i = 0; i < 300; i++) step(1, 16'(16'h3000 + i), 0, 0, 1);
        check("sat_drops", 32'(drop_count), 32'd255);
        check("sat_ovf",   32'(overflow),   32'd1);
        step(0, '0, 0, 1, 1);
        check("sclr_count", 32'(count),      32'd0);
        check("sclr_ovf",   32'(overflow),   32'd0);
        check("sclr_drops", 32'(drop_count), 32'd0);
        check("sclr_empty", 32'(empty),      32'd1);

        // Alternate push / pop for 40 words: pointers wrap twice.
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 16'(16'h2000 + i), 0, 0, 1);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            check("alt_word", 32'(out_data), 32'(16'h2000 + i));
            step(0, '0, 1, 0, 1);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        check("alt_max_count", 32'(max_cnt), 32'd1);

        // Reset mid-stream with 5 words held; reset wins over everything.
        for (int i = 0; i < 5; i++) step(1, 16'(16'h4000 + i), 0, 0, 1);
        check("pre_rst_count", 32'(count), 32'd5);
        step(1, 16'h5555, 1, 1, 0);
        step(1, 16'h5555, 1, 1, 0);
        check("mrst_count", 32'(count),      32'd0);
        check("mrst_valid", 32'(out_valid),  32'd0);
        check("mrst_data",  32'(out_data),   32'h0);
        check("mrst_empty", 32'(empty),      32'd1);
        check("mrst_drops", 32'(drop_count), 32'd0);
        step(1, 16'h00C3, 0, 0, 1);
        check("post_rst_data",  32'(out_data), 32'h00C3);
        check("post_rst_count", 32'(count),    32'd1);
        step(0, '0, 1, 0, 1);
        check("post_rst_drain", 32'(empty), 32'd1);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
